fcmp_ctrl: RTL and testbench

Two-stage, valid/ready-handshaked controller that sequences single-precision compare and min/max operations (FLT, FLE, FEQ, FMIN, FMAX) for the FP execute stage. Stage 1 registers the operands and opcode. Stage 2 evaluates the comparison flags and selects the result with full RISC-V NaN and signed-zero semantics. It also produces the NV exception flag. It sits between the FP issue logic and the FP writeback mux, and supports backpressure and pipeline flush.

---
 rtl/fcmp_pkg.sv | 18 +
 rtl/fcmp_ctrl_flags.sv | 23 ++
 rtl/fcmp_ctrl.sv | 114 +++++++++++
 tb/tb_fcmp_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared op encoding, canonical NaN constant and binary32 NaN classifiers
// Exports fcmp_op_e, FP_CANON_NAN, is_nan(), is_snan().
package fcmp_pkg;
   typedef enum logic [2:0] {
      OP_FLT  = 3'd0,
      OP_FLE  = 3'd1,
      OP_FEQ  = 3'd2,
      OP_FMIN = 3'd3,
      OP_FMAX = 3'd4
   } fcmp_op_e;
   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
   function automatic logic is_nan(input logic [31:0] f);
      return f[30:23] == 8'hFF && f[22:0] != 23'd0;
   endfunction
   function automatic logic is_snan(input logic [31:0] f);
      return is_nan(f) && !f[22];
   endfunction
endpackage

// File: rtl/fcmp_ctrl_flags.sv
// fp_cmp_flags: combinational binary32 ordering and NaN classification
// Ports: i_a, i_b operands; o_lt/o_gt/o_eq ordering (meaningless if o_any_nan); o_any_nan, o_any_snan.
module fp_cmp_flags
   import fcmp_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_lt,
   output logic        o_gt,
   output logic        o_eq,
   output logic        o_any_nan,
   output logic        o_any_snan
);
   logic both_zero;
   assign both_zero  = (i_a[30:0] | i_b[30:0]) == 31'd0;
   assign o_eq       = both_zero || i_a == i_b;
   // Sign-magnitude order: differing signs decide directly, negatives invert magnitude order.
   assign o_lt       = !o_eq && ((i_a[31] != i_b[31]) ? i_a[31] :
                        i_a[31] ? (i_a[30:0] > i_b[30:0]) : (i_a[30:0] < i_b[30:0]));
   assign o_gt       = !o_eq && !o_lt;
   assign o_any_nan  = is_nan(i_a) || is_nan(i_b);
   assign o_any_snan = is_snan(i_a) || is_snan(i_b);
endmodule

// File: rtl/fcmp_ctrl.sv
// fcmp_ctrl: two-stage valid/ready FP compare and min/max controller (FLT/FLE/FEQ/FMIN/FMAX)
// Ports: i_clk, i_rst (sync, active-high), i_flush; request i_valid/o_ready/i_op/i_rs1_f/i_rs2_f/i_tag;
//        result o_valid/i_ready/o_result/o_tag/o_nv.
// Config: define FCMP_MINMAX_EN to build FMIN/FMAX; otherwise op codes 3 and 4 behave as illegal.
module fcmp_ctrl
   import fcmp_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_rs1_f,
   input  logic [31:0] i_rs2_f,
   input  logic [4:0]  i_tag,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic [4:0]  o_tag,
   output logic        o_nv
);
   logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [2:0]  s1_op_q, s1_op_d;
   logic [31:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d, s2_result_q, s2_result_d;
   logic [4:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
   logic        s2_nv_q, s2_nv_d;
   logic        s1_load, s2_load, take, adv;
   logic        lt, gt, eq, any_nan, any_snan;
   logic [31:0] res;
   logic        nv;

   fp_cmp_flags u_flags (
      .i_a        (s1_rs1_q),
      .i_b        (s1_rs2_q),
      .o_lt       (lt),
      .o_gt       (gt),
      .o_eq       (eq),
      .o_any_nan  (any_nan),
      .o_any_snan (any_snan)
   );

   assign s2_load  = !s2_valid_q || i_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign o_ready  = s1_load;
   assign take     = s1_load && i_valid;
   assign adv      = s2_load && s1_valid_q;
   assign o_valid  = s2_valid_q;
   assign o_result = s2_result_q;
   assign o_tag    = s2_tag_q;
   assign o_nv     = s2_nv_q;

`ifdef FCMP_MINMAX_EN
   logic [31:0] min_res, max_res, mm_res;
   logic        a_nan, b_nan;
   assign a_nan   = is_nan(s1_rs1_q);
   assign b_nan   = is_nan(s1_rs2_q);
   // On equality the operands differ only for +0/-0: OR the signs for min, AND them for max.
   assign min_res = lt ? s1_rs1_q : eq ? {s1_rs1_q[31] | s1_rs2_q[31], s1_rs1_q[30:0]} : s1_rs2_q;
   assign max_res = gt ? s1_rs1_q : eq ? {s1_rs1_q[31] & s1_rs2_q[31], s1_rs1_q[30:0]} : s1_rs2_q;
   assign mm_res  = (a_nan && b_nan) ? FP_CANON_NAN : a_nan ? s1_rs2_q : b_nan ? s1_rs1_q :
                    (s1_op_q == OP_FMIN) ? min_res : max_res;
`endif

   always_comb begin
      res = '0;
      nv  = 1'b0;
      case (s1_op_q)
         OP_FLT: begin res[0] = !any_nan && lt;  nv = any_nan;  end
         OP_FLE: begin res[0] = !any_nan && !gt; nv = any_nan;  end
         OP_FEQ: begin res[0] = !any_nan && eq;  nv = any_snan; end
`ifdef FCMP_MINMAX_EN
         OP_FMIN, OP_FMAX: begin res = mm_res; nv = any_snan; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      s1_valid_d  = i_flush ? 1'b0 : s1_load ? i_valid : s1_valid_q;
      s1_op_d     = take ? i_op : s1_op_q;
      s1_rs1_d    = take ? i_rs1_f : s1_rs1_q;
      s1_rs2_d    = take ? i_rs2_f : s1_rs2_q;
      s1_tag_d    = take ? i_tag : s1_tag_q;
      s2_valid_d  = i_flush ? 1'b0 : s2_load ? s1_valid_q : s2_valid_q;
      s2_result_d = adv ? res : s2_result_q;
      s2_tag_d    = adv ? s1_tag_q : s2_tag_q;
      s2_nv_d     = adv ? nv : s2_nv_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_rs1_q    <= '0;
         s1_rs2_q    <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_tag_q    <= '0;
         s2_nv_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_rs1_q    <= s1_rs1_d;
         s1_rs2_q    <= s1_rs2_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_tag_q    <= s2_tag_d;
         s2_nv_q     <= s2_nv_d;
      end
   end
endmodule

// File: tb/tb_fcmp_ctrl.sv
// tb_fcmp_ctrl: scoreboard bench for fcmp_ctrl (directed vectors, streaming with stall, flush, mid-run reset)
module tb_fcmp_ctrl;
   logic        clk = 1'b0, rst, i_flush, i_valid, i_ready;
   logic [2:0]  i_op;
   logic [31:0] i_rs1_f, i_rs2_f;
   logic [4:0]  i_tag;
   logic        o_ready, o_valid, o_nv;
   logic [31:0] o_result;
   logic [4:0]  o_tag;
   int          total = 0, bad = 0;
   logic [37:0] q[$];

`ifdef FCMP_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a, b, res;
      logic        nv;
   } vec_t;
   vec_t dv[15];
   logic [31:0] pool[10];

   fcmp_ctrl dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_flush  (i_flush),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_rs1_f  (i_rs1_f),
      .i_rs2_f  (i_rs2_f),
      .i_tag    (i_tag),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_tag    (o_tag),
      .o_nv     (o_nv)
   );

   always #5 clk = ~clk;

   // Reference: map floats to an unsigned total-order key (both zeros share one key).
   function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic nx, ny, sx, sy, lt, eq;
      logic [31:0] kx, ky, mn, mx;
      nx = x[30:23] == 8'hFF && x[22:0] != 0;
      ny = y[30:23] == 8'hFF && y[22:0] != 0;
      sx = nx && !x[22];
      sy = ny && !y[22];
      kx = (x[30:0] == 0) ? 32'h8000_0000 : x[31] ? ~x : {1'b1, x[30:0]};
      ky = (y[30:0] == 0) ? 32'h8000_0000 : y[31] ? ~y : {1'b1, y[30:0]};
      lt = kx < ky;
      eq = kx == ky;
      mn = (nx && ny) ? 32'h7FC0_0000 : nx ? y : ny ? x :
           (eq && x[30:0] == 0) ? {x[31] | y[31], 31'b0} : lt ? x : y;
      mx = (nx && ny) ? 32'h7FC0_0000 : nx ? y : ny ? x :
           (eq && x[30:0] == 0) ? {x[31] & y[31], 31'b0} : lt ? y : x;
      case (o)
         3'd0: return {31'b0, !(nx | ny) && lt, nx | ny};
         3'd1: return {31'b0, !(nx | ny) && (lt | eq), nx | ny};
         3'd2: return {31'b0, !(nx | ny) && eq, sx | sy};
         3'd3: return MM ? {mn, sx | sy} : 33'd0;
         3'd4: return MM ? {mx, sx | sy} : 33'd0;
         default: return 33'd0;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_op = '0; i_rs1_f = '0; i_rs2_f = '0; i_tag = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({o_valid, o_result, o_tag, o_nv, o_ready} !== {1'b0, 32'b0, 5'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset: got v=%b r=%h t=%h nv=%b rdy=%b need v=0 r=0 t=0 nv=0 rdy=1",
                  o_valid, o_result, o_tag, o_nv, o_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int lat;
      logic [37:0] e;
      dv = '{
         {3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h1, 1'b0},
         {3'd1, 32'h4000_0000, 32'h3F80_0000, 32'h0, 1'b0},
         {3'd2, 32'h7F80_0001, 32'h3F80_0000, 32'h0, 1'b1},
         {3'd2, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, 1'b0},
         {3'd0, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, 1'b1},
         {3'd2, 32'h8000_0000, 32'h0000_0000, 32'h1, 1'b0},
         {3'd1, 32'hBF80_0000, 32'hC000_0000, 32'h0, 1'b0},
         {3'd0, 32'hC000_0000, 32'hBF80_0000, 32'h1, 1'b0},
         {3'd3, 32'h8000_0000, 32'h0000_0000, MM ? 32'h8000_0000 : 32'h0, 1'b0},
         {3'd4, 32'h0000_0000, 32'h8000_0000, 32'h0, 1'b0},
         {3'd4, 32'h7FC0_0000, 32'h4040_0000, MM ? 32'h4040_0000 : 32'h0, 1'b0},
         {3'd3, 32'h7FC0_0000, 32'h7FC0_0000, MM ? 32'h7FC0_0000 : 32'h0, 1'b0},
         {3'd3, 32'h7F80_0001, 32'h3F80_0000, MM ? 32'h3F80_0000 : 32'h0, MM},
         {3'd4, 32'hBF80_0000, 32'hC000_0000, MM ? 32'hBF80_0000 : 32'h0, 1'b0},
         {3'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0}
      };
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         i_valid = 1'b1; i_op = dv[i].op; i_rs1_f = dv[i].a; i_rs2_f = dv[i].b; i_tag = 5'(i);
         q.push_back({5'(i), dv[i].res, dv[i].nv});
         @(negedge clk);
         i_valid = 1'b0;
         lat = 1;
         while (!o_valid && lat < 6) begin
            @(negedge clk);
            lat++;
         end
         e = q.pop_front();
         total++;
         if (!o_valid || lat != 2 || {o_tag, o_result, o_nv} !== e) begin
            bad++;
            $display("FAIL directed[%0d]: got v=%b lat=%0d t=%h r=%h nv=%b need v=1 lat=2 t=%h r=%h nv=%b",
                     i, o_valid, lat, o_tag, o_result, o_nv, e[37:33], e[32:1], e[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0, got = 0, cyc = 0;
      bit prev_stall = 1'b0, saw_block = 1'b0;
      logic [37:0] held = '0, e;
      logic [2:0] cop = 3'($urandom_range(0, 5));
      logic [31:0] ca = pool[$urandom_range(0, 9)], cb = pool[$urandom_range(0, 9)];
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         i_ready = !(cyc >= 4 && cyc < 7);
         i_valid = sent < 8;
         i_op = cop; i_rs1_f = ca; i_rs2_f = cb; i_tag = 5'(sent + 8);
         #1;
         if (prev_stall) begin
            total++;
            if ({o_valid, o_tag, o_result, o_nv} !== {1'b1, held}) begin
               bad++;
               $display("FAIL stall_hold: got v=%b t=%h r=%h nv=%b need v=1 t=%h r=%h nv=%b",
                        o_valid, o_tag, o_result, o_nv, held[37:33], held[32:1], held[0]);
            end
         end
         if (i_ready) begin
            total++;
            if (o_ready !== 1'b1) begin
               bad++;
               $display("FAIL ready_flow: got o_ready=%b need 1", o_ready);
            end
         end
         if (o_valid && i_ready) begin
            e = (q.size() != 0) ? q.pop_front() : 38'h3F_FFFF_FFFF;
            total++;
            if ({o_tag, o_result, o_nv} !== e) begin
               bad++;
               $display("FAIL stream_retire: got t=%h r=%h nv=%b need t=%h r=%h nv=%b",
                        o_tag, o_result, o_nv, e[37:33], e[32:1], e[0]);
            end
            got++;
         end
         prev_stall = o_valid && !i_ready;
         held = {o_tag, o_result, o_nv};
         if (!i_ready && !o_ready) saw_block = 1'b1;
         if (i_valid && o_ready) begin
            q.push_back({i_tag, model(cop, ca, cb)});
            sent++;
            cop = 3'($urandom_range(0, 5));
            ca = pool[$urandom_range(0, 9)];
            cb = pool[$urandom_range(0, 9)];
         end
         cyc++;
      end
      i_valid = 1'b0; i_ready = 1'b1;
      total++;
      if (got != 8 || q.size() != 0 || !saw_block) begin
         bad++;
         $display("FAIL stream_summary: got retired=%0d left=%0d blocked=%b need 8 0 1", got, q.size(), saw_block);
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_extra: got o_valid=%b need 0", o_valid);
         end
      end
   endtask

   task automatic test_flush();
      int lat;
      logic [37:0] e;
      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         i_valid = 1'b1; i_op = 3'd0; i_rs1_f = 32'h3F80_0000; i_rs2_f = 32'h4000_0000; i_tag = 5'(20 + i);
         i_flush = (i == 2);
      end
      @(negedge clk);
      i_flush = 1'b0; i_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill[%0d]: got o_valid=%b need 0", k, o_valid);
         end
         @(negedge clk);
      end
      i_valid = 1'b1; i_op = 3'd2; i_rs1_f = 32'h3F80_0000; i_rs2_f = 32'h3F80_0000; i_tag = 5'd23;
      q.push_back({5'd23, model(3'd2, 32'h3F80_0000, 32'h3F80_0000)});
      @(negedge clk);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      e = q.pop_front();
      total++;
      if (!o_valid || lat != 2 || {o_tag, o_result, o_nv} !== e) begin
         bad++;
         $display("FAIL flush_after: got v=%b lat=%0d t=%h r=%h nv=%b need v=1 lat=2 t=%h r=%h nv=%b",
                  o_valid, lat, o_tag, o_result, o_nv, e[37:33], e[32:1], e[0]);
      end
   endtask

   task automatic test_rst_mid();
      int lat;
      logic [37:0] e;
      i_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         i_valid = 1'b1; i_op = 3'd1; i_rs1_f = 32'h4040_0000; i_rs2_f = 32'h4040_0000; i_tag = 5'(28 + i);
      end
      @(negedge clk);
      i_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      total++;
      if ({o_valid, o_result, o_tag, o_nv, o_ready} !== {1'b0, 32'b0, 5'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rst_mid: got v=%b r=%h t=%h nv=%b rdy=%b need v=0 r=0 t=0 nv=0 rdy=1",
                  o_valid, o_result, o_tag, o_nv, o_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      i_valid = 1'b1; i_op = 3'd0; i_rs1_f = 32'hC000_0000; i_rs2_f = 32'h0000_0000; i_tag = 5'd31;
      q.push_back({5'd31, model(3'd0, 32'hC000_0000, 32'h0000_0000)});
      @(negedge clk);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      e = q.pop_front();
      total++;
      if (!o_valid || lat != 2 || {o_tag, o_result, o_nv} !== e) begin
         bad++;
         $display("FAIL rst_after: got v=%b lat=%0d t=%h r=%h nv=%b need v=1 lat=2 t=%h r=%h nv=%b",
                  o_valid, lat, o_tag, o_result, o_nv, e[37:33], e[32:1], e[0]);
      end
   endtask

   initial begin
      pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
               32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'hC040_0000};
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
